// File: rtl/spi_slave_rx_if.sv
// Pin-level and byte-level signals of the oversampled SPI slave receiver.
// spi_frame_err exists only when SPI_SLAVE_FRAME_ERR_EN is defined.
interface spi_slave_rx_if;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [7:0] spi_slave_byte;
  logic       spi_slave_data_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       spi_frame_err;
`endif

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, tx_byte,
    output spi_miso, spi_miso_oe, tx_load, spi_slave_byte, spi_slave_data_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , output spi_frame_err
`endif
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, tx_byte,
    input  spi_miso, spi_miso_oe, tx_load, spi_slave_byte, spi_slave_data_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , input spi_frame_err
`endif
  );
endinterface

// File: rtl/spi_slave_rx.sv
// Oversampled full-duplex SPI slave byte engine running in the clk domain.
// Optional SPI_SLAVE_FRAME_ERR_EN adds spi_frame_err (CS released mid-byte).
module spi_slave_rx #(
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst,
  spi_slave_rx_if.slave spi
);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  state_e     state_q;

  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic       cs_s1_q, cs_s2_q, cs_s3_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [1:0] settle_q;
  logic       armed_q;

  logic [2:0] bit_cnt_q;
  logic [7:0] rx_sr_q;
  logic [7:0] tx_sr_q;
  logic [7:0] byte_q;
  logic       valid_q;
  logic       tx_load_q;
  logic       miso_q;
  logic       oe_q;
  logic       fresh_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       ferr_q;
`endif

  logic       sck_rise, sck_fall, lead_edge, trail_edge;
  logic       sample_edge, shift_edge, cs_fall, byte_done;
  logic [7:0] rx_shift_d;
  logic [7:0] tx_shift_d;

  function automatic logic first_bit(input logic [7:0] v);
    return MSB_FIRST ? v[7] : v[0];
  endfunction

  function automatic logic second_bit(input logic [7:0] v);
    return MSB_FIRST ? v[6] : v[1];
  endfunction

  // Two-flop synchronisers; the third sck/cs flop only feeds edge detection,
  // so mosi_s2_q is already aligned with the detected sck edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1_q  <= CPOL;
      sck_s2_q  <= CPOL;
      sck_s3_q  <= CPOL;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      settle_q  <= '0;
      armed_q   <= 1'b0;
    end else begin
      sck_s1_q  <= spi.spi_sck;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      cs_s1_q   <= spi.spi_cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= spi.spi_mosi;
      mosi_s2_q <= mosi_s1_q;
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
      // A frame already selected when reset releases is ignored: a real cs_n
      // high must be seen before a falling edge is accepted.
      if (settle_q == 2'd3 && cs_s2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    sck_rise    = sck_s2_q & ~sck_s3_q;
    sck_fall    = ~sck_s2_q & sck_s3_q;
    lead_edge   = CPOL ? sck_fall : sck_rise;
    trail_edge  = CPOL ? sck_rise : sck_fall;
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    cs_fall     = ~cs_s2_q & cs_s3_q;
    byte_done   = sample_edge && (bit_cnt_q == 3'd7);
    rx_shift_d  = MSB_FIRST ? {rx_sr_q[6:0], mosi_s2_q} : {mosi_s2_q, rx_sr_q[7:1]};
    tx_shift_d  = MSB_FIRST ? {tx_sr_q[6:0], 1'b0} : {1'b0, tx_sr_q[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      tx_load_q <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      fresh_q   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ferr_q    <= 1'b0;
`endif
    end else begin
      valid_q   <= 1'b0;
      tx_load_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ferr_q    <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          oe_q      <= 1'b0;
          miso_q    <= 1'b0;
          if (cs_fall && armed_q) begin
            state_q   <= ST_ACTIVE;
            rx_sr_q   <= '0;
            tx_sr_q   <= spi.tx_byte;
            tx_load_q <= 1'b1;
            oe_q      <= 1'b1;
            if (!CPHA) begin
              miso_q  <= first_bit(spi.tx_byte);
              fresh_q <= 1'b0;
            end else begin
              fresh_q <= 1'b1;
            end
          end
        end

        ST_ACTIVE: begin
          if (sample_edge) begin
            rx_sr_q   <= rx_shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          // A freshly loaded byte has its first bit put on the wire by the
          // next shift edge without shifting; later shift edges advance.
          if (byte_done) begin
            byte_q    <= rx_shift_d;
            valid_q   <= 1'b1;
            tx_sr_q   <= spi.tx_byte;
            tx_load_q <= 1'b1;
            fresh_q   <= 1'b1;
          end
          if (shift_edge) begin
            if (fresh_q) begin
              miso_q  <= first_bit(tx_sr_q);
              fresh_q <= 1'b0;
            end else begin
              tx_sr_q <= tx_shift_d;
              miso_q  <= second_bit(tx_sr_q);
            end
          end
          // Deselect wins over the bit logic, but a byte completing in the
          // same cycle still produces its valid pulse above.
          if (cs_s2_q) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            oe_q      <= 1'b0;
            miso_q    <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            ferr_q    <= (bit_cnt_q != 3'd0) && !byte_done;
`endif
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi.spi_miso             = miso_q;
  assign spi.spi_miso_oe          = oe_q;
  assign spi.tx_load              = tx_load_q;
  assign spi.spi_slave_byte       = byte_q;
  assign spi.spi_slave_data_valid = valid_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign spi.spi_frame_err        = ferr_q;
`endif

endmodule
